// File: rtl/aemb2_pkg.sv
// Shared AEMB2 FSL controller types and constants.
package aemb2_pkg;

  // FSL controller states
  //   state | meaning
  //   IDLE  | waiting for an FSL op from execute
  //   BUSY  | CWB cycle outstanding, pipeline stalled
  //   DONE  | completion cycle: result/carry valid, pipeline released
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsl_state_t;

  // Bit positions inside cwb_tga_o
  localparam int FSL_TGA_NB  = 1;
  localparam int FSL_TGA_CTL = 0;

  // Default non-blocking window, in strobe cycles
  localparam int FSL_TMO = 4;

endpackage

// File: rtl/aemb2_fsl_tmo.sv
// Saturating timeout counter for non-blocking FSL accesses.
// expire_o flags the last strobe cycle of the TMO-cycle window.
module aemb2_fsl_tmo import aemb2_pkg::*; #(
  parameter int TMO = FSL_TMO
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] C_MAX = CW'(TMO);
  localparam logic [CW-1:0] C_EXP = CW'(TMO - 1);

  logic [CW-1:0] r_cnt;

  // count BUSY cycles without ack, hold at TMO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_cnt <= '0;
    else if (clr_i)
      r_cnt <= '0;
    else if (en_i && (r_cnt != C_MAX))
      r_cnt <= r_cnt + 1'b1;
  end

  assign expire_o = (r_cnt == C_EXP);

endmodule

// File: rtl/aemb2_fsl_ctrl.sv
// AEMB2 FSL/CWB transaction controller: single-beat GET/PUT sequencing,
// pipeline hold, blocking/non-blocking semantics and carry generation.
// Optional bus-error support is enabled by defining AEMB2_FSL_ERR_EN.
module aemb2_fsl_ctrl import aemb2_pkg::*; #(
  parameter int TMO = FSL_TMO
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fsl_req_i,
  input  logic        fsl_we_i,
  input  logic        fsl_nb_i,
  input  logic        fsl_ctl_i,
  input  logic [4:0]  fsl_adr_i,
  input  logic [31:0] fsl_dat_i,
  output logic [4:0]  cwb_adr_o,
  output logic [1:0]  cwb_tga_o,
  output logic [3:0]  cwb_sel_o,
  output logic        cwb_cyc_o,
  output logic        cwb_stb_o,
  output logic        cwb_we_o,
  output logic [31:0] cwb_dat_o,
  input  logic [31:0] cwb_dat_i,
  input  logic        cwb_ack_i,
`ifdef AEMB2_FSL_ERR_EN
  input  logic        cwb_err_i,
  output logic        fsl_err_o,
`endif
  output logic        ena_o,
  output logic        fsl_vld_o,
  output logic [31:0] fsl_dat_o,
  output logic        fsl_c_o
);

  fsl_state_t  r_state;
  fsl_state_t  w_state_nxt;
  logic [4:0]  r_adr;
  logic [1:0]  r_tga;
  logic        r_we;
  logic [31:0] r_wdat;
  logic [31:0] r_rdat;
  logic        r_c;
  logic        w_err;
  logic        w_expire;
  logic        w_busy;
  logic        w_idle;
  logic        w_term;
  logic        w_c_nxt;
  logic        w_capture;
  logic        w_start;

`ifdef AEMB2_FSL_ERR_EN
  logic r_err;
  assign w_err = cwb_err_i;
`else
  assign w_err = 1'b0;
`endif

  assign w_busy  = (r_state == BUSY);
  assign w_idle  = (r_state == IDLE);
  assign w_start = w_idle & fsl_req_i;

  aemb2_fsl_tmo #(.TMO(TMO)) u_tmo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (w_idle),
    .en_i     (w_busy & ~cwb_ack_i),
    .expire_o (w_expire)
  );

  // next-state and termination decode; err beats ack beats timeout
  always_comb begin
    w_state_nxt = r_state;
    w_term      = 1'b0;
    w_c_nxt     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (fsl_req_i) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_err) begin
          w_state_nxt = DONE;
          w_term      = 1'b1;
          w_c_nxt     = 1'b1;
        end else if (cwb_ack_i) begin
          w_state_nxt = DONE;
          w_term      = 1'b1;
          w_capture   = ~r_we;
        end else if (r_tga[FSL_TGA_NB] && w_expire) begin
          w_state_nxt = DONE;
          w_term      = 1'b1;
          w_c_nxt     = 1'b1;
        end
      end
      DONE: begin
        // the stalled instruction is still presented here; never restart on it
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // latch the request onto the CWB side at acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_adr  <= '0;
      r_tga  <= '0;
      r_we   <= 1'b0;
      r_wdat <= '0;
    end else if (w_start) begin
      r_adr              <= fsl_adr_i;
      r_tga[FSL_TGA_NB]  <= fsl_nb_i;
      r_tga[FSL_TGA_CTL] <= fsl_ctl_i;
      r_we               <= fsl_we_i;
      r_wdat             <= fsl_dat_i;
    end
  end

  // GET data and carry, held until the next completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdat <= '0;
      r_c    <= 1'b0;
    end else begin
      if (w_capture) r_rdat <= cwb_dat_i;
      if (w_term)    r_c    <= w_c_nxt;
    end
  end

`ifdef AEMB2_FSL_ERR_EN
  // remember whether the termination was a bus error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_err <= 1'b0;
    else if (w_term) r_err <= w_err;
  end
  assign fsl_err_o = (r_state == DONE) & r_err;
`endif

  assign cwb_adr_o = r_adr;
  assign cwb_tga_o = r_tga;
  assign cwb_we_o  = r_we;
  assign cwb_dat_o = r_wdat;
  assign cwb_cyc_o = w_busy;
  assign cwb_stb_o = w_busy;
  assign cwb_sel_o = w_busy ? 4'hF : 4'h0;
  assign ena_o     = ~w_start & ~w_busy;
  assign fsl_vld_o = (r_state == DONE);
  assign fsl_dat_o = r_rdat;
  assign fsl_c_o   = r_c;

endmodule

// File: tb/tb_aemb2_fsl_ctrl.sv
// Self-checking bench for aemb2_fsl_ctrl (optionally with AEMB2_FSL_ERR_EN).
module tb_aemb2_fsl_ctrl;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fsl_req_i, fsl_we_i, fsl_nb_i, fsl_ctl_i;
  logic [4:0]  fsl_adr_i;
  logic [31:0] fsl_dat_i;
  logic [4:0]  cwb_adr_o;
  logic [1:0]  cwb_tga_o;
  logic [3:0]  cwb_sel_o;
  logic        cwb_cyc_o, cwb_stb_o, cwb_we_o;
  logic [31:0] cwb_dat_o;
  logic [31:0] cwb_dat_i;
  logic        cwb_ack_i;
`ifdef AEMB2_FSL_ERR_EN
  logic        cwb_err_i;
  logic        fsl_err_o;
`endif
  logic        ena_o, fsl_vld_o;
  logic [31:0] fsl_dat_o;
  logic        fsl_c_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_dat;   // reference: last GET result the core should see

  always #5 clk_i = ~clk_i;

  aemb2_fsl_ctrl #(.TMO(TMO)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .fsl_req_i (fsl_req_i),
    .fsl_we_i  (fsl_we_i),
    .fsl_nb_i  (fsl_nb_i),
    .fsl_ctl_i (fsl_ctl_i),
    .fsl_adr_i (fsl_adr_i),
    .fsl_dat_i (fsl_dat_i),
    .cwb_adr_o (cwb_adr_o),
    .cwb_tga_o (cwb_tga_o),
    .cwb_sel_o (cwb_sel_o),
    .cwb_cyc_o (cwb_cyc_o),
    .cwb_stb_o (cwb_stb_o),
    .cwb_we_o  (cwb_we_o),
    .cwb_dat_o (cwb_dat_o),
    .cwb_dat_i (cwb_dat_i),
    .cwb_ack_i (cwb_ack_i),
`ifdef AEMB2_FSL_ERR_EN
    .cwb_err_i (cwb_err_i),
    .fsl_err_o (fsl_err_o),
`endif
    .ena_o     (ena_o),
    .fsl_vld_o (fsl_vld_o),
    .fsl_dat_o (fsl_dat_o),
    .fsl_c_o   (fsl_c_o)
  );

  // One FSL op. ack_at is the cycle (0 = request cycle) in which ack is
  // driven, -1 for never. Ends one clock after the completion cycle, then
  // idles for gap cycles with req low.
  task automatic run_txn(input logic we, input logic nb, input logic ctl,
                         input logic [4:0] adr, input logic [31:0] dat,
                         input int ack_at, input logic [31:0] ack_dat,
                         input int gap, input string tag);
    logic        hit;
    int          term;
    int          stall = 0, stbs = 0, vld_at = -1;
    logic        c_seen = 1'b0;
    logic [31:0] d_seen = '0, o_seen = '0;
    logic [4:0]  a_seen = '0;
    logic [1:0]  t_seen = '0;
    logic        w_seen = 1'b0;
    logic [3:0]  s_seen = '0;
    // blocking ops complete on ack only; non-blocking ones also after TMO strobes
    hit  = (ack_at >= 1) && (!nb || ack_at <= TMO);
    term = hit ? ack_at : TMO;
    fsl_req_i = 1'b1; fsl_we_i = we; fsl_nb_i = nb; fsl_ctl_i = ctl;
    fsl_adr_i = adr;  fsl_dat_i = dat;
    for (int i = 0; i < 40 && vld_at < 0; i++) begin
      cwb_ack_i = (i == ack_at);
      cwb_dat_i = (i == ack_at) ? ack_dat : $urandom;
      @(negedge clk_i);
      if (!ena_o)    stall++;
      if (cwb_stb_o) stbs++;
      if (i == 1) begin
        a_seen = cwb_adr_o; t_seen = cwb_tga_o; w_seen = cwb_we_o;
        o_seen = cwb_dat_o; s_seen = cwb_sel_o;
      end
      if (fsl_vld_o) begin
        vld_at = i; c_seen = fsl_c_o; d_seen = fsl_dat_o;
      end
      @(posedge clk_i); #1;
      fsl_dat_i = $urandom;  // request fields are don't-care after acceptance
    end
    cwb_ack_i = 1'b0;
    if (hit && !we) m_dat = ack_dat;

    n_cmp++;
    if (vld_at < 0) begin
      n_bad++;
      $display("FAIL %s completion: no fsl_vld_o within 40 cycles, required at cycle %0d", tag, term + 1);
    end else begin
      n_cmp++;
      if (vld_at !== term + 1) begin
        n_bad++; $display("FAIL %s vld_cycle: got %0d want %0d", tag, vld_at, term + 1);
      end
      n_cmp++;
      if (stall !== term + 1) begin
        n_bad++; $display("FAIL %s stall: got %0d want %0d", tag, stall, term + 1);
      end
      n_cmp++;
      if (stbs !== term) begin
        n_bad++; $display("FAIL %s stb_cycles: got %0d want %0d", tag, stbs, term);
      end
      n_cmp++;
      if (c_seen !== !hit) begin
        n_bad++; $display("FAIL %s carry: got %b want %b", tag, c_seen, !hit);
      end
      n_cmp++;
      if (d_seen !== m_dat) begin
        n_bad++; $display("FAIL %s fsl_dat: got %h want %h", tag, d_seen, m_dat);
      end
    end
    n_cmp++;
    if (a_seen !== adr || t_seen !== {nb, ctl} || w_seen !== we || o_seen !== dat || s_seen !== 4'hF) begin
      n_bad++;
      $display("FAIL %s cwb_fields: got adr=%h tga=%b we=%b dat=%h sel=%h want adr=%h tga=%b we=%b dat=%h sel=F",
               tag, a_seen, t_seen, w_seen, o_seen, s_seen, adr, {nb, ctl}, we, dat);
    end
    if (gap > 0) begin
      fsl_req_i = 1'b0;
      repeat (gap) begin
        @(negedge clk_i);
        n_cmp++;
        if (ena_o !== 1'b1 || cwb_stb_o !== 1'b0 || fsl_vld_o !== 1'b0 || fsl_dat_o !== m_dat) begin
          n_bad++;
          $display("FAIL %s idle_after: got ena=%b stb=%b vld=%b dat=%h want ena=1 stb=0 vld=0 dat=%h",
                   tag, ena_o, cwb_stb_o, fsl_vld_o, fsl_dat_o, m_dat);
        end
        @(posedge clk_i); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    fsl_req_i = 0; fsl_we_i = 0; fsl_nb_i = 0; fsl_ctl_i = 0;
    fsl_adr_i = '0; fsl_dat_i = '0; cwb_dat_i = '0; cwb_ack_i = 0;
`ifdef AEMB2_FSL_ERR_EN
    cwb_err_i = 0;
`endif
    m_dat = '0;
    @(negedge clk_i);
    n_cmp++;
    if (cwb_cyc_o !== 0 || cwb_stb_o !== 0 || cwb_we_o !== 0 || fsl_vld_o !== 0 ||
        cwb_sel_o !== 4'h0 || cwb_adr_o !== 5'h0 || cwb_tga_o !== 2'b00 ||
        cwb_dat_o !== 32'h0 || fsl_dat_o !== 32'h0 || fsl_c_o !== 0 || ena_o !== 1) begin
      n_bad++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b vld=%b sel=%h adr=%h tga=%b wdat=%h rdat=%h c=%b ena=%b want all zero, ena=1",
               cwb_cyc_o, cwb_stb_o, cwb_we_o, fsl_vld_o, cwb_sel_o, cwb_adr_o, cwb_tga_o,
               cwb_dat_o, fsl_dat_o, fsl_c_o, ena_o);
    end
`ifdef AEMB2_FSL_ERR_EN
    n_cmp++;
    if (fsl_err_o !== 0) begin
      n_bad++; $display("FAIL reset_err: got %b want 0", fsl_err_o);
    end
`endif
    fsl_req_i = 1'b1;
    #1;
    n_cmp++;
    if (ena_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_ena_comb: got %b want 0", ena_o);
    end
    fsl_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_blocking_get();
    run_txn(1'b0, 1'b0, 1'b0, 5'h03, 32'h0, 3, 32'hDEADBEEF, 1, "blk_get");
  endtask

  task automatic test_nb_put_timeout();
    run_txn(1'b1, 1'b1, 1'b0, 5'h11, 32'h12345678, -1, 32'h0, 1, "nb_put_tmo");
  endtask

  task automatic test_nb_get_ack_at_expiry();
    run_txn(1'b0, 1'b1, 1'b1, 5'h1C, 32'hA5A5A5A5, TMO, 32'hCAFEF00D, 1, "nb_get_edge");
  endtask

  task automatic test_async_reset();
    int vlds = 0;
    fsl_req_i = 1'b1; fsl_we_i = 1'b0; fsl_nb_i = 1'b0; fsl_ctl_i = 1'b0;
    fsl_adr_i = 5'h07; fsl_dat_i = 32'h0;
    repeat (2) begin @(posedge clk_i); #1; end
    @(negedge clk_i); #2;
    n_cmp++;
    if (cwb_stb_o !== 1'b1) begin
      n_bad++; $display("FAIL arst_pre: got stb=%b want 1", cwb_stb_o);
    end
    rst_ni = 1'b0;
    fsl_req_i = 1'b0;
    #1;
    n_cmp++;
    if (cwb_stb_o !== 0 || cwb_cyc_o !== 0 || cwb_sel_o !== 4'h0 || cwb_adr_o !== 5'h0) begin
      n_bad++;
      $display("FAIL arst_drop: got stb=%b cyc=%b sel=%h adr=%h want 0 0 0 0",
               cwb_stb_o, cwb_cyc_o, cwb_sel_o, cwb_adr_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    m_dat = '0;
    repeat (3) begin
      @(negedge clk_i);
      if (fsl_vld_o) vlds++;
      n_cmp++;
      if (ena_o !== 1'b1 || cwb_stb_o !== 1'b0) begin
        n_bad++; $display("FAIL arst_idle: got ena=%b stb=%b want 1 0", ena_o, cwb_stb_o);
      end
      @(posedge clk_i); #1;
    end
    n_cmp++;
    if (vlds !== 0 || fsl_dat_o !== 32'h0 || fsl_c_o !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_after: got vlds=%0d dat=%h c=%b want 0 0 0", vlds, fsl_dat_o, fsl_c_o);
    end
  endtask

  // monitor of all completion pulses
  int vld_total = 0;
  always @(negedge clk_i) if (fsl_vld_o === 1'b1) vld_total++;

  task automatic test_back_to_back();
    int v0;
    v0 = vld_total;
    // req stays high through DONE, one idle cycle, then a new op
    run_txn(1'b0, 1'b0, 1'b0, 5'h02, 32'h0, 1, 32'h0BADF00D, 1, "b2b_first");
    run_txn(1'b0, 1'b0, 1'b1, 5'h04, 32'h0, 2, 32'h55AA33CC, 0, "b2b_second");
    // earliest restart: req held straight into the IDLE cycle
    run_txn(1'b1, 1'b0, 1'b0, 5'h05, 32'h87654321, 1, 32'h0, 1, "b2b_third");
    n_cmp++;
    if (vld_total - v0 !== 3) begin
      n_bad++; $display("FAIL b2b_vld_count: got %0d want 3", vld_total - v0);
    end
    // late ack while idle must not produce a completion or capture data
    v0 = vld_total;
    cwb_ack_i = 1'b1; cwb_dat_i = 32'hFFFF0000;
    repeat (2) begin
      @(negedge clk_i);
      n_cmp++;
      if (cwb_stb_o !== 1'b0 || ena_o !== 1'b1) begin
        n_bad++; $display("FAIL late_ack_bus: got stb=%b ena=%b want 0 1", cwb_stb_o, ena_o);
      end
      @(posedge clk_i); #1;
    end
    cwb_ack_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (vld_total - v0 !== 0 || fsl_dat_o !== m_dat) begin
      n_bad++;
      $display("FAIL late_ack: got vlds=%0d dat=%h want 0 %h", vld_total - v0, fsl_dat_o, m_dat);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_random();
    logic nb;
    int   ack_at;
    for (int n = 0; n < 24; n++) begin
      nb     = 1'($urandom_range(0, 1));
      ack_at = nb ? $urandom_range(0, TMO + 2) : $urandom_range(1, 6);
      if (nb && ack_at == 0) ack_at = -1;
      run_txn(1'($urandom_range(0, 1)), nb, 1'($urandom_range(0, 1)),
              5'($urandom), $urandom, ack_at, $urandom,
              $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end
    fsl_req_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

`ifdef AEMB2_FSL_ERR_EN
  task automatic test_err();
    int          errs = 0, vld_at = -1;
    logic        c_seen = 1'b0, e_seen = 1'b0;
    logic [31:0] d_seen = '0;
    fsl_req_i = 1'b1; fsl_we_i = 1'b0; fsl_nb_i = 1'b0; fsl_ctl_i = 1'b0;
    fsl_adr_i = 5'h09; fsl_dat_i = 32'h0;
    for (int i = 0; i < 20 && vld_at < 0; i++) begin
      cwb_ack_i = (i == 2); cwb_err_i = (i == 2); cwb_dat_i = 32'h13579BDF;
      @(negedge clk_i);
      if (fsl_err_o) errs++;
      if (fsl_vld_o) begin vld_at = i; c_seen = fsl_c_o; e_seen = fsl_err_o; d_seen = fsl_dat_o; end
      @(posedge clk_i); #1;
    end
    cwb_ack_i = 0; cwb_err_i = 0; fsl_req_i = 0;
    n_cmp++;
    if (vld_at !== 3 || e_seen !== 1'b1 || errs !== 1 || c_seen !== 1'b1 || d_seen !== m_dat) begin
      n_bad++;
      $display("FAIL err_ack: got vld_at=%0d err=%b errs=%0d c=%b dat=%h want 3 1 1 1 %h",
               vld_at, e_seen, errs, c_seen, d_seen, m_dat);
    end
    @(posedge clk_i); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_blocking_get();
    test_nb_put_timeout();
    test_nb_get_ack_at_expiry();
    test_async_reset();
    test_back_to_back();
    test_random();
`ifdef AEMB2_FSL_ERR_EN
    test_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aemb2_fsl_ctrl.md
# aemb2_fsl_ctrl

FSL/coprocessor-bus (CWB) transaction controller for the AEMB2 core. It takes the GET/PUT request that the execute stage decodes and sequences it onto the CWB wishbone port as a single-beat transaction. It holds the pipeline while the transaction is outstanding, enforces the MicroBlaze blocking/non-blocking semantics with a timeout, and returns read data plus the carry (failure) flag to the ASLU MSR logic.

## Interface
- TMO, 4: non-blocking window in cycles with stb asserted; legal range ≥1.
- clk_i  in  1  core clock; all state on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- fsl_req_i  in  1  FSL op present in execute. Held high while the pipeline is stalled.
- fsl_we_i  in  1  1 = PUT, 0 = GET.
- fsl_nb_i  in  1  non-blocking (n bit).
- fsl_ctl_i  in  1  control access (c bit).
- fsl_adr_i  in  5  FSL channel, [6:2].
- fsl_dat_i  in  32  PUT data.
- cwb_adr_o  out  5  latched channel.
- cwb_tga_o  out  2  {nb, ctl}.
- cwb_sel_o  out  4  4'hF during a transaction, else 4'h0.
- cwb_cyc_o, cwb_stb_o  out  1  bus cycle/strobe (identical).
- cwb_we_o  out  1  latched fsl_we_i.
- cwb_dat_o  out  32  latched PUT data.
- cwb_dat_i  in  32  GET data.
- cwb_ack_i  in  1  transaction accept.
- cwb_err_i  in  1  bus error. Present only with AEMB2_FSL_ERR_EN.
- ena_o  out  1  pipeline enable; low = stall.
- fsl_vld_o  out  1  one-cycle completion pulse.
- fsl_dat_o  out  32  GET result. Held until the next completion.
- fsl_c_o  out  1  carry to write into MSR_C; valid with fsl_vld_o.
- fsl_err_o  out  1  error pulse. Present only with AEMB2_FSL_ERR_EN.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - On fsl_req_i, latch adr/tga/we/dat into the cwb_* registers and go to BUSY.
  - Timeout counter clears to 0.
- **BUSY**
  - cyc/stb high, sel = F.
  - Counter increments each BUSY cycle without ack; it saturates at TMO.
  - cwb_ack_i=1: capture cwb_dat_i into fsl_dat_o (GET only; a PUT leaves fsl_dat_o unchanged), set c=0, go to DONE.
  - fsl_nb_i latched=1 and counter==TMO-1 with no ack: set c=1, go to DONE. No bus side effects.
  - Blocking accesses never time out.
- **DONE**
  - cyc/stb low, fsl_vld_o=1, ena_o=1, then IDLE.
  - fsl_req_i is ignored in DONE. The same instruction is still visible that cycle and must not restart.
- ena_o = ~(IDLE & fsl_req_i) & ~BUSY. This is a combinational path from fsl_req_i.
- Ack in the same cycle as timeout: ack wins, c=0.
- Ack or err seen in IDLE or DONE: ignored.
- Reset (any state, including mid-BUSY):
  - state IDLE; cyc/stb/we/vld/err low.
  - sel 0, adr 0, tga 0.
  - cwb_dat_o 0, fsl_dat_o 0, fsl_c_o 0, counter 0.
  - ena_o follows its equation.

## Timing
- req high in IDLE at cycle N: ena_o low in N; cyc/stb high from N+1.
- Ack sampled at N+k (k≥1): DONE at N+k+1 with fsl_vld_o, fsl_dat_o and ena_o high. IDLE at N+k+2.
- Stall length is k+1 cycles (N..N+k).
- Zero-wait slave (ack at N+1): minimum 2-cycle stall, vld at N+2.
- Non-blocking miss: stb high for exactly TMO cycles (N+1..N+TMO); DONE at N+TMO+1 with c=1.
- Back-to-back FSL ops: the earliest next request is accepted at N+k+2.

## Configuration
- **AEMB2_FSL_ERR_EN defined:**
  - cwb_err_i and fsl_err_o ports exist.
  - err in BUSY terminates like ack: fsl_dat_o unchanged, c=1, fsl_err_o pulses with fsl_vld_o.
  - Simultaneous ack and err: err wins.
- **Undefined:** both ports are absent and an ack or timeout is the only termination.

## Structure
- Shared package aemb2_pkg holds:
  - state enum fsl_state_t {IDLE, BUSY, DONE};
  - tga bit indices FSL_TGA_NB=1, FSL_TGA_CTL=0;
  - default FSL_TMO=4.
- One natural sub-module, aemb2_fsl_tmo: a saturating timeout counter with clear/enable inputs and an expire output. Counter width is $clog2(TMO+1).

## Test plan
- **Blocking GET, ack at 3rd stb cycle:** req with we=0, nb=0, adr=5'h03; cwb_dat_i=32'hDEADBEEF.
  - Expected: ena_o low 4 cycles, fsl_vld_o once, fsl_dat_o=DEADBEEF, fsl_c_o=0, cwb_adr_o=3, tga=00.
- **Non-blocking PUT, no ack, TMO=4:** dat=32'h12345678.
  - Expected: stb high exactly 4 cycles, cwb_dat_o=12345678, then vld with c=1.
- **Non-blocking GET, ack on the TMO-th cycle:** ack and expiry coincide.
  - Expected: c=0, data captured.
- **Async reset pulse mid-BUSY:**
  - Expected: cyc/stb drop without a clock edge.
  - After release with req low, controller is IDLE and ena_o=1; no vld produced.
- **req held through DONE plus a 1-cycle gap, then a new req:**
  - Expected: exactly two transactions, two vld pulses.
  - A late ack arriving in IDLE is ignored.
- **AEMB2_FSL_ERR_EN build, err and ack together:**
  - Expected: fsl_err_o=1, c=1, fsl_dat_o unchanged.
